float_result_buffer: RTL and testbench

- Downstream stage of the combinational float multiplier: captures each product and its overflow/underflow/inexact flags through a valid/ready handshake, applies exception fixup (saturate to infinity or flush to signed zero) and buffers results in a DEPTH-entry FIFO for the consumer.
- Maintains sticky exception status and an accepted-result counter for software/debug readout.

---
 rtl/float_result_buffer.sv | 99 +++++++++
 tb/tb_float_result_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/float_result_buffer.sv
// Result buffer behind the float multiplier: exception fixup at capture, a small
// FIFO towards the consumer, plus sticky exception status and a result counter.
module float_result_buffer #(
    parameter int FLOAT_SIZE    = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int DEPTH         = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_SIZE-1:0]  in_float,
    input  logic                   in_overflow,
    input  logic                   in_underflow,
    input  logic                   in_inexact,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_SIZE-1:0]  out_float,
    output logic [2:0]             out_flags,
    input  logic                   clear_sticky,
    output logic [2:0]             sticky_flags,
    output logic [COUNT_WIDTH-1:0] result_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [FLOAT_SIZE-1:0] mem_float [DEPTH];
    logic [2:0]            mem_flags [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occupancy;
    logic [FLOAT_SIZE-1:0] fixed_float;
    logic [2:0]            in_flags;
    logic                  push;
    logic                  pop;

    // Handshake status comes only from the occupancy register, never from the inputs.
    assign in_ready  = (occupancy != OCC_W'(DEPTH));
    assign out_valid = (occupancy != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_flags  = {in_overflow, in_underflow, in_inexact};

    assign out_float = mem_float[rd_ptr];
    assign out_flags = mem_flags[rd_ptr];

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        fixed_float = in_float;
        if (in_overflow) begin
            fixed_float = {in_float[FLOAT_SIZE-1], {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
        end else if (in_underflow) begin
            fixed_float = {in_float[FLOAT_SIZE-1], {(FLOAT_SIZE-1){1'b0}}};
        end
    end

    // NOTE: the storage array is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_float[wr_ptr] <= fixed_float;
            mem_flags[wr_ptr] <= in_flags;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            sticky_flags <= '0;
            result_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase

            // A clear in the same cycle as a push keeps only the new flags.
            if (push) begin
                sticky_flags <= (clear_sticky ? 3'b000 : sticky_flags) | in_flags;
            end else if (clear_sticky) begin
                sticky_flags <= 3'b000;
            end

            if (push && (result_count != {COUNT_WIDTH{1'b1}})) begin
                result_count <= result_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_float_result_buffer.sv
// Directed bench for float_result_buffer: fixup, FIFO ordering and full/empty
// limits, sticky status, counter saturation (second instance, 2-bit counter) and reset.
module tb_float_result_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_float;
    logic        in_overflow;
    logic        in_underflow;
    logic        in_inexact;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic [2:0]  out_flags;
    logic        clear_sticky;
    logic [2:0]  sticky_flags;
    logic [15:0] result_count;

    logic        s_reset;
    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_out_float;
    logic [2:0]  s_out_flags;
    logic [2:0]  s_sticky_flags;
    logic [1:0]  s_result_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    float_result_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_float     (in_float),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .in_inexact   (in_inexact),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_float    (out_float),
        .out_flags    (out_flags),
        .clear_sticky (clear_sticky),
        .sticky_flags (sticky_flags),
        .result_count (result_count)
    );

    float_result_buffer #(.COUNT_WIDTH(2)) dut_sat (
        .clk          (clk),
        .reset        (s_reset),
        .in_valid     (s_in_valid),
        .in_ready     (s_in_ready),
        .in_float     (32'h3F800000),
        .in_overflow  (1'b0),
        .in_underflow (1'b0),
        .in_inexact   (1'b0),
        .out_valid    (s_out_valid),
        .out_ready    (s_out_ready),
        .out_float    (s_out_float),
        .out_flags    (s_out_flags),
        .clear_sticky (1'b0),
        .sticky_flags (s_sticky_flags),
        .result_count (s_result_count)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] f, input logic ov, input logic un, input logic ix);
        in_valid     = 1'b1;
        in_float     = f;
        in_overflow  = ov;
        in_underflow = un;
        in_inexact   = ix;
        tick();
        in_valid     = 1'b0;
        in_overflow  = 1'b0;
        in_underflow = 1'b0;
        in_inexact   = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_q [4];

        reset = 1'b1; in_valid = 1'b0; in_float = '0; in_overflow = 1'b0;
        in_underflow = 1'b0; in_inexact = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
        s_reset = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        s_reset = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sticky", 32'(sticky_flags), 32'd0);
        check("rst_count", 32'(result_count), 32'd0);

        // Plain value passes unchanged, one cycle latency.
        push_one(32'h40400000, 1'b0, 1'b0, 1'b0);
        check("plain_valid", 32'(out_valid), 32'd1);
        check("plain_float", out_float, 32'h40400000);
        check("plain_flags", 32'(out_flags), 32'd0);
        check("plain_count", 32'(result_count), 32'd1);
        check("plain_sticky", 32'(sticky_flags), 32'd0);
        pop_one();
        check("plain_empty", 32'(out_valid), 32'd0);

        // Exception fixup.
        push_one(32'h80123456, 1'b1, 1'b0, 1'b0);
        check("ovf_float", out_float, 32'hFF800000);
        check("ovf_flags", 32'(out_flags), 32'h4);
        pop_one();
        push_one(32'h00400001, 1'b0, 1'b1, 1'b0);
        check("unf_float", out_float, 32'h00000000);
        check("unf_flags", 32'(out_flags), 32'h2);
        pop_one();
        push_one(32'h7F000000, 1'b1, 1'b1, 1'b0);
        check("both_float", out_float, 32'h7F800000);
        check("both_flags", 32'(out_flags), 32'h6);
        pop_one();
        check("fix_sticky", 32'(sticky_flags), 32'h6);
        check("fix_count", 32'(result_count), 32'd4);
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;

        // Fill to full, refused fifth push, drain in order.
        exp_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 32'(in_ready), 32'd1);
            push_one(exp_q[i], 1'b0, 1'b0, 1'b0);
        end
        check("full_ready", 32'(in_ready), 32'd0);
        push_one(32'h40A00000, 1'b0, 1'b0, 1'b0);
        check("full_ready2", 32'(in_ready), 32'd0);
        check("full_count", 32'(result_count), 32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_float", out_float, exp_q[i]);
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_ready", 32'(in_ready), 32'd1);

        // Full with push and pop together: pop happens, push refused.
        exp_q = '{32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};
        for (int i = 0; i < 4; i++) push_one(exp_q[i], 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b1;
        in_float  = 32'h41400000;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_ready", 32'(in_ready), 32'd1);
        check("pp_head", out_float, 32'h41100000);
        check("pp_count", 32'(result_count), 32'd12);
        tick();
        in_valid = 1'b0;
        check("pp_full", 32'(in_ready), 32'd0);
        check("pp_count2", 32'(result_count), 32'd13);
        exp_q = '{32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_drain", out_float, exp_q[i]);
            tick();
        end
        out_ready = 1'b0;
        check("pp_empty", 32'(out_valid), 32'd0);

        // Sticky accumulation and clearing.
        check("stk_start", 32'(sticky_flags), 32'd0);
        push_one(32'h3F800001, 1'b0, 1'b0, 1'b1);
        check("stk_inexact", 32'(sticky_flags), 32'h1);
        push_one(32'h7F7FFFFF, 1'b1, 1'b0, 1'b0);
        check("stk_ovf", 32'(sticky_flags), 32'h5);
        pop_one();
        pop_one();
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        check("stk_clear", 32'(sticky_flags), 32'h0);
        push_one(32'h3F800001, 1'b0, 1'b0, 1'b1);
        clear_sticky = 1'b1;
        push_one(32'h00000001, 1'b0, 1'b1, 1'b0);
        clear_sticky = 1'b0;
        check("stk_clr_push", 32'(sticky_flags), 32'h2);

        // Reset with two entries buffered and traffic on the inputs.
        check("rst2_valid_pre", 32'(out_valid), 32'd1);
        in_valid  = 1'b1;
        in_float  = 32'h3F800000;
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_ready", 32'(in_ready), 32'd1);
        check("rst2_count", 32'(result_count), 32'd0);
        check("rst2_sticky", 32'(sticky_flags), 32'd0);

        // 2-bit counter saturates at 3.
        s_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_count", 32'(s_result_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        s_in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
